// File: rtl/accumulate_unit.sv
// accumulate_unit: push-button driven 16-bit accumulator.
// Run and Clear are synchronized. Each qualified Run press performs one
// Acc <= Acc + SW through a combinational two-level carry-lookahead adder.
// Cout and Ovf hold the flags of the most recent add.
module accumulate_unit (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Run,
  input  logic        Clear,
  input  logic [15:0] SW,
  output logic [15:0] Acc,
  output logic        Cout,
  output logic        Ovf,
  output logic        Busy,
  output logic        Done
);

  typedef enum logic [1:0] {S_IDLE, S_LATCH, S_ADD, S_DONE} state_t;

  state_t      state_reg, state_next;
  logic        run_meta_reg, run_s_reg, run_prev_reg;
  logic        clr_meta_reg, clr_s_reg;
  logic [1:0]  warm_reg;
  logic        armed_reg;
  logic [15:0] acc_reg, b_reg;
  logic        cout_reg, ovf_reg;
  logic        run_edge;

  // Adder nets
  logic        cin;
  logic [15:0] bit_g, bit_p;
  logic [15:0] carry;
  logic [3:0]  grp_g, grp_p;
  logic [4:0]  grp_c;
  logic [16:0] sum;

  // Input synchronizers, edge flop, and post-reset arming.
  // After reset the synchronizers hold zeros that do not reflect the real
  // input. Arming therefore waits until the synchronized Run has been seen
  // low, so that a button held through reset cannot start an add.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      run_meta_reg <= 1'b0;
      run_s_reg    <= 1'b0;
      run_prev_reg <= 1'b0;
      clr_meta_reg <= 1'b0;
      clr_s_reg    <= 1'b0;
      warm_reg     <= 2'd0;
      armed_reg    <= 1'b0;
    end else begin
      run_meta_reg <= Run;
      run_s_reg    <= run_meta_reg;
      run_prev_reg <= run_s_reg;
      clr_meta_reg <= Clear;
      clr_s_reg    <= clr_meta_reg;
      if (warm_reg != 2'd2) begin
        warm_reg <= warm_reg + 2'd1;
      end
      if (warm_reg == 2'd2 && !run_s_reg) begin
        armed_reg <= 1'b1;
      end
    end
  end

  assign run_edge = armed_reg & run_s_reg & ~run_prev_reg;

  // State register
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state logic. A clear in the same IDLE cycle as a Run edge wins.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:  if (run_edge && !clr_s_reg) state_next = S_LATCH;
      S_LATCH: state_next = S_ADD;
      S_ADD:   state_next = S_DONE;
      S_DONE:  if (!run_s_reg) state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Carry-lookahead adder: 4-bit lookahead groups with a lookahead carry
  // network across the groups. Carry-in is fixed at zero.
  assign cin   = 1'b0;
  assign bit_g = acc_reg & b_reg;
  assign bit_p = acc_reg ^ b_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_cla
      localparam int B0 = 4 * gi;
      assign carry[B0]   = grp_c[gi];
      assign carry[B0+1] = bit_g[B0] | (bit_p[B0] & grp_c[gi]);
      assign carry[B0+2] = bit_g[B0+1] | (bit_p[B0+1] & bit_g[B0])
                         | (bit_p[B0+1] & bit_p[B0] & grp_c[gi]);
      assign carry[B0+3] = bit_g[B0+2] | (bit_p[B0+2] & bit_g[B0+1])
                         | (bit_p[B0+2] & bit_p[B0+1] & bit_g[B0])
                         | (bit_p[B0+2] & bit_p[B0+1] & bit_p[B0] & grp_c[gi]);
      assign grp_g[gi]   = bit_g[B0+3] | (bit_p[B0+3] & bit_g[B0+2])
                         | (bit_p[B0+3] & bit_p[B0+2] & bit_g[B0+1])
                         | (bit_p[B0+3] & bit_p[B0+2] & bit_p[B0+1] & bit_g[B0]);
      assign grp_p[gi]   = &bit_p[B0+3:B0];
    end
  endgenerate

  assign grp_c[0] = cin;
  assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
  assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
  assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
  assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                  | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

  assign sum = {grp_c[4], bit_p ^ carry};

  // Datapath: latch the operand, commit the sum and flags, or clear when idle or done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      acc_reg  <= 16'd0;
      b_reg    <= 16'd0;
      cout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      case (state_reg)
        S_LATCH: b_reg <= SW;
        S_ADD: begin
          acc_reg  <= sum[15:0];
          cout_reg <= sum[16];
          ovf_reg  <= (acc_reg[15] == b_reg[15]) && (sum[15] != acc_reg[15]);
        end
        default: begin
          if (clr_s_reg) begin
            acc_reg  <= 16'd0;
            cout_reg <= 1'b0;
            ovf_reg  <= 1'b0;
          end
        end
      endcase
    end
  end

  assign Acc  = acc_reg;
  assign Cout = cout_reg;
  assign Ovf  = ovf_reg;
  assign Busy = (state_reg == S_LATCH) || (state_reg == S_ADD);
  assign Done = (state_reg == S_DONE);

endmodule

// File: tb/tb_accumulate_unit.sv
// Directed self-checking bench for accumulate_unit. Each press pushes its
// expected {Cout, Ovf, Acc} to a scoreboard queue. A monitor pops that entry
// and compares it when Done rises.
module tb_accumulate_unit;

  logic        Clk;
  logic        Reset;
  logic        Run;
  logic        Clear;
  logic [15:0] SW;
  logic [15:0] Acc;
  logic        Cout;
  logic        Ovf;
  logic        Busy;
  logic        Done;

  int          total = 0;
  int          bad   = 0;
  logic [17:0] sb_q[$];
  logic [15:0] model_acc = 16'd0;
  logic        done_prev = 1'b0;

  accumulate_unit dut (
    .Clk  (Clk),
    .Reset(Reset),
    .Run  (Run),
    .Clear(Clear),
    .SW   (SW),
    .Acc  (Acc),
    .Cout (Cout),
    .Ovf  (Ovf),
    .Busy (Busy),
    .Done (Done)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL timeout reached before test end");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(negedge Clk);
  endtask

  // Independent arithmetic model of one add
  task automatic push_add(input logic [15:0] sw);
    logic [16:0] s;
    logic        o;
    s = {1'b0, model_acc} + {1'b0, sw};
    o = (model_acc[15] == sw[15]) && (s[15] != model_acc[15]);
    sb_q.push_back({s[16], o, s[15:0]});
    model_acc = s[15:0];
  endtask

  // One press: checks the LATCH/ADD/DONE timing, perturbs SW mid-flight,
  // holds Run for a while, then releases it.
  task automatic press(input logic [15:0] sw, input int hold);
    SW  = sw;
    Run = 1'b1;
    push_add(sw);
    step(3);
    chk("latch_busy", {31'd0, Busy}, 32'd1);
    chk("latch_done", {31'd0, Done}, 32'd0);
    step(1);
    chk("add_busy", {31'd0, Busy}, 32'd1);
    SW = ~sw;
    step(1);
    chk("done_rise", {31'd0, Done}, 32'd1);
    chk("done_busy", {31'd0, Busy}, 32'd0);
    if (hold > 0) begin
      step(hold);
      chk("done_held", {31'd0, Done}, 32'd1);
    end
    Run = 1'b0;
    step(3);
    chk("idle_done", {31'd0, Done}, 32'd0);
  endtask

  task automatic do_clear();
    Clear = 1'b1;
    step(3);
    chk("clr_acc", {16'd0, Acc}, 32'd0);
    chk("clr_cout", {31'd0, Cout}, 32'd0);
    chk("clr_ovf", {31'd0, Ovf}, 32'd0);
    Clear = 1'b0;
    step(3);
    model_acc = 16'd0;
    $display("clear: acc=%h", Acc);
  endtask

  // Scoreboard monitor: compare the expected result when Done rises
  always @(negedge Clk) begin
    logic [17:0] e;
    if (Done && !done_prev) begin
      total++;
      assert (sb_q.size() != 0) else begin
        bad++;
        $error("FAIL unexpected_add got acc=%h exp=no add", Acc);
      end
      if (sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("sb_acc", {16'd0, Acc}, {16'd0, e[15:0]});
        chk("sb_cout", {31'd0, Cout}, {31'd0, e[17]});
        chk("sb_ovf", {31'd0, Ovf}, {31'd0, e[16]});
        $display("add: acc=%h cout=%0d ovf=%0d (exp acc=%h cout=%0d ovf=%0d)",
                 Acc, Cout, Ovf, e[15:0], e[17], e[16]);
      end
    end
    done_prev = Done;
  end

  initial begin
    Reset = 1'b1;
    Run   = 1'b0;
    Clear = 1'b0;
    SW    = 16'd0;
    step(3);
    chk("rst_acc", {16'd0, Acc}, 32'd0);
    chk("rst_cout", {31'd0, Cout}, 32'd0);
    chk("rst_ovf", {31'd0, Ovf}, 32'd0);
    chk("rst_busy", {31'd0, Busy}, 32'd0);
    chk("rst_done", {31'd0, Done}, 32'd0);
    Reset = 1'b0;
    step(5);

    // Basic add with Done held while Run is held
    press(16'h0005, 4);

    // Signed overflow, then carry plus overflow
    do_clear();
    press(16'h7FFF, 0);
    press(16'h0001, 0);
    press(16'h8000, 0);

    // Wrap with carry, no overflow; the clear afterwards drops Cout
    do_clear();
    press(16'hFFFF, 0);
    press(16'h0001, 0);
    do_clear();

    // Long hold produces exactly one add
    press(16'h0003, 20);
    step(2);
    chk("hold_acc", {16'd0, Acc}, 32'h3);

    // Run and Clear together in IDLE: clear wins, no add
    do_clear();
    press(16'h1234, 0);
    Run   = 1'b1;
    Clear = 1'b1;
    step(5);
    chk("rc_acc", {16'd0, Acc}, 32'd0);
    chk("rc_busy", {31'd0, Busy}, 32'd0);
    chk("rc_done", {31'd0, Done}, 32'd0);
    model_acc = 16'd0;
    Clear = 1'b0;
    step(6);
    chk("rc_noadd", {16'd0, Acc}, 32'd0);
    Run = 1'b0;
    step(4);
    $display("run+clear: acc=%h", Acc);

    // Reset during ADD discards the add; Run held through reset is ignored
    press(16'h0010, 0);
    SW  = 16'h0005;
    Run = 1'b1;
    step(4);
    chk("pre_rst_busy", {31'd0, Busy}, 32'd1);
    Reset = 1'b1;
    step(1);
    chk("midrst_acc", {16'd0, Acc}, 32'd0);
    chk("midrst_busy", {31'd0, Busy}, 32'd0);
    chk("midrst_done", {31'd0, Done}, 32'd0);
    Reset     = 1'b0;
    model_acc = 16'd0;
    step(12);
    chk("held_noadd_acc", {16'd0, Acc}, 32'd0);
    chk("held_noadd_busy", {31'd0, Busy}, 32'd0);
    Run = 1'b0;
    step(4);
    $display("reset-in-add: acc=%h", Acc);
    press(16'h0007, 0);

    step(3);
    chk("sb_empty", sb_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/accumulate_unit.md
ACCUMULATE_UNIT -- requirements
Module: accumulate_unit

Interface
REQ-001 SHALL have port Clk, input, 1, system clock; all state updates on rising edge.
REQ-002 SHALL have port Reset, input, 1, synchronous active-high reset.
REQ-003 SHALL have port Run, input, 1, asynchronous push-button level; a rising edge requests one accumulate.
REQ-004 SHALL have port Clear, input, 1, asynchronous push-button level; high requests accumulator clear.
REQ-005 SHALL have port SW, input, 16, operand from switches, two's complement.
REQ-006 SHALL have port Acc, output, 16, accumulator register value.
REQ-007 SHALL have port Cout, output, 1, carry out of the last add.
REQ-008 SHALL have port Ovf, output, 1, signed overflow of the last add.
REQ-009 SHALL have port Busy, output, 1, high while in LATCH or ADD.
REQ-010 SHALL have port Done, output, 1, high while in DONE.

Function
REQ-011 SHALL pass Run and Clear each through a 2-flop synchronizer (run_s, clr_s); raw inputs drive no other logic.
REQ-012 SHALL detect a Run edge as run_s=1 and the previous run_s=0 (one extra flop).
REQ-013 SHALL implement states IDLE, LATCH, ADD, DONE; registered state, one-hot or binary.
REQ-014 IDLE: on a Run edge with clr_s=0 -> LATCH next cycle; otherwise stay.
REQ-015 LATCH: register B <= SW; -> ADD unconditionally.
REQ-016 ADD: {Cout, Acc} <= Acc + B (17-bit result); Ovf <= (Acc[15]==B[15]) && (sum[15]!=Acc[15]); -> DONE unconditionally.
REQ-017 DONE: stay while run_s=1; -> IDLE on the first cycle run_s=0.
REQ-018 The sum SHALL come from a combinational 16-bit carry-lookahead adder with cin=0; the adder is not registered internally.
REQ-019 Clear: when clr_s=1 in IDLE or DONE, Acc, Cout, Ovf <= 0 that cycle; state unchanged.
REQ-020 Clear SHALL be ignored in LATCH and ADD; the add completes normally.
REQ-021 Run edge and clr_s=1 in the same IDLE cycle: clear wins, the Run edge is discarded, and no add occurs until the next Run edge.
REQ-022 Holding Run high SHALL produce exactly one add; a new add requires release, which returns the block to IDLE, then a new press.
REQ-023 Latency: Run rises before edge k; the Run edge is detected at edge k+2 (IDLE->LATCH); B is loaded at edge k+3; Acc updates and Done rises at edge k+4.
REQ-024 Acc SHALL wrap modulo 2^16; Cout and Ovf reflect only the most recent add and hold until the next add, Clear or Reset.
REQ-025 SW changes after LATCH SHALL not affect the in-flight add.

Reset
REQ-026 Reset=1 at a clock edge SHALL set state=IDLE and clear Acc, B, Cout, Ovf, both synchronizers and the edge flop to 0, so Busy=0 and Done=0.
REQ-027 Reset SHALL take priority over all other inputs in any state, including mid-LATCH or mid-ADD; the interrupted add is discarded.
REQ-028 After Reset deasserts with Run held high, no add SHALL occur until Run is released and pressed again.

Verification
REQ-029 Reset, SW=0x0005, pulse Run -> Acc=0x0005, Cout=0, Ovf=0, Done high from edge k+4 until Run is released.
REQ-030 Acc=0x7FFF, SW=0x0001, Run -> Acc=0x8000, Ovf=1, Cout=0; then SW=0x8000, Run -> Acc=0x0000, Cout=1, Ovf=1.
REQ-031 Acc=0xFFFF, SW=0x0001, Run -> Acc=0x0000, Cout=1, Ovf=0.
REQ-032 Hold Run high for 20 cycles with SW=0x0003 from Acc=0 -> exactly one add, Acc=0x0003.
REQ-033 Raise Run and Clear together in IDLE with Acc=0x1234 -> Acc=0x0000, no add, state stays IDLE.
REQ-034 Assert Reset in the ADD cycle with Acc=0x0010 -> Acc=0x0000, state IDLE, Busy=0, Done=0 on the next cycle.
